// File: rtl/ball_pkg.sv
// Shared definitions for the tilt-driven ball stepper: axis state encoding,
// tilt bit positions and signed direction codes.
package ball_pkg;

  typedef enum logic [1:0] {
    AX_IDLE = 2'd0,
    AX_QUAL = 2'd1,
    AX_MOVE = 2'd2
  } axis_state_t;

  localparam int TILT_LEFT  = 0;
  localparam int TILT_RIGHT = 1;
  localparam int TILT_FWD   = 2;
  localparam int TILT_BACK  = 3;

  localparam logic signed [1:0] DIR_NONE = 2'sb00;
  localparam logic signed [1:0] DIR_POS  = 2'sb01;
  localparam logic signed [1:0] DIR_NEG  = 2'sb11;

endpackage

// File: rtl/tilt_axis_stepper.sv
// One axis of the ball stepper: direction qualification FSM, speed, and clamped position step.
// BALL_ACCEL_EN defined: speed ramps 1,2,..,MAX_SPEED while the direction is held.
module tilt_axis_stepper
  import ball_pkg::*;
#(
  parameter int POS_W      = 10,
  parameter int MAX_POS    = 639,
  parameter int INIT_POS   = 320,
  parameter int QUAL_TICKS = 3,
  parameter int MAX_SPEED  = 4
) (
  input  logic              SYSCLK,
  input  logic              reset2,
  input  logic              tick,
  input  logic signed [1:0] dir,
  input  logic              freeze,
  input  logic              recenter,
  output logic [POS_W-1:0]  pos,
  output logic              stepped,
  output logic              clamped,
  output logic              in_move
);

  localparam int CNT_W = (QUAL_TICKS < 2) ? 1 : $clog2(QUAL_TICKS);
  localparam int SPD_W = $clog2(MAX_SPEED + 1);
  localparam int SUM_W = POS_W + 2;
  localparam bit QUAL_NOW = (QUAL_TICKS == 1);
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_POS);

  axis_state_t       state_p0, state_n;
  logic [CNT_W-1:0]  cnt_p0, cnt_n;
  logic signed [1:0] hold_p0, hold_n;
  logic [SPD_W-1:0]  speed_p0, speed_n;
  logic              step_p1, step_n;
  logic              restart;

  logic signed [SUM_W-1:0] pos_s, spd_s, sum_s;

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])  return '0;
    else if (v > MAX_S) return POS_W'(MAX_POS);
    else             return v[POS_W-1:0];
  endfunction

  function automatic logic is_clamped(input logic signed [SUM_W-1:0] v);
    return v[SUM_W-1] || (v > MAX_S);
  endfunction

`ifdef BALL_ACCEL_EN
  function automatic logic [SPD_W-1:0] ramp_speed(input logic [SPD_W-1:0] s);
    if (s >= SPD_W'(MAX_SPEED)) return SPD_W'(MAX_SPEED);
    else                        return s + 1'b1;
  endfunction
`endif

  always_comb begin
    state_n = state_p0;
    cnt_n   = cnt_p0;
    hold_n  = hold_p0;
    speed_n = speed_p0;
    step_n  = 1'b0;
    restart = 1'b0;
    if (freeze) begin
      state_n = AX_IDLE;
      cnt_n   = '0;
      speed_n = '0;
    end else if (tick) begin
      unique case (state_p0)
        AX_IDLE: begin
          if (dir != DIR_NONE) restart = 1'b1;
        end
        AX_QUAL: begin
          if (dir == DIR_NONE) begin
            state_n = AX_IDLE;
            cnt_n   = '0;
          end else if (dir == hold_p0) begin
            if (cnt_p0 == CNT_W'(QUAL_TICKS - 1)) begin
              state_n = AX_MOVE;
              cnt_n   = '0;
              speed_n = SPD_W'(1);
            end else begin
              cnt_n = cnt_p0 + 1'b1;
            end
          end else begin
            restart = 1'b1;
          end
        end
        AX_MOVE: begin
          if (dir == DIR_NONE) begin
            state_n = AX_IDLE;
            speed_n = '0;
          end else if (dir == hold_p0) begin
`ifdef BALL_ACCEL_EN
            speed_n = ramp_speed(speed_p0);
`else
            speed_n = SPD_W'(1);
`endif
          end else begin
            restart = 1'b1;
          end
        end
        default: begin
          state_n = AX_IDLE;
          cnt_n   = '0;
          speed_n = '0;
        end
      endcase
      // A new or reversed direction starts qualification from one tick.
      if (restart) begin
        hold_n = dir;
        if (QUAL_NOW) begin
          state_n = AX_MOVE;
          cnt_n   = '0;
          speed_n = SPD_W'(1);
        end else begin
          state_n = AX_QUAL;
          cnt_n   = CNT_W'(1);
          speed_n = '0;
        end
      end
      step_n = (state_n == AX_MOVE);
    end
  end

  // Stage p0/p1: FSM state and the pending-step flag for the following edge
  always_ff @(posedge SYSCLK or negedge reset2) begin
    if (!reset2) begin
      state_p0 <= AX_IDLE;
      cnt_p0   <= '0;
      hold_p0  <= DIR_NONE;
      speed_p0 <= '0;
      step_p1  <= 1'b0;
    end else begin
      state_p0 <= state_n;
      cnt_p0   <= cnt_n;
      hold_p0  <= hold_n;
      speed_p0 <= speed_n;
      step_p1  <= step_n;
    end
  end

  assign pos_s = signed'({2'b00, pos});
  assign spd_s = signed'({{(SUM_W - SPD_W){1'b0}}, speed_p0});
  assign sum_s = hold_p0[1] ? (pos_s - spd_s) : (pos_s + spd_s);

  // Stage p2: position update; recenter wins over a coincident step
  always_ff @(posedge SYSCLK or negedge reset2) begin
    if (!reset2) begin
      pos     <= POS_W'(INIT_POS);
      stepped <= 1'b0;
      clamped <= 1'b0;
    end else begin
      stepped <= 1'b0;
      clamped <= 1'b0;
      if (recenter) begin
        pos <= POS_W'(INIT_POS);
      end else if (step_p1 && !freeze) begin
        pos     <= clamp_pos(sum_s);
        stepped <= 1'b1;
        clamped <= is_clamped(sum_s);
      end
    end
  end

  assign in_move = (state_p0 == AX_MOVE);

endmodule

// File: rtl/ball_tilt_stepper.sv
// Ball position stepper: frame-tick divider, tilt decode and two axis steppers.
// Define BALL_ACCEL_EN to ramp step speed up to MAX_SPEED while a tilt is held.
module ball_tilt_stepper
  import ball_pkg::*;
#(
  parameter int SYSCLK_FREQUENCY_HZ = 100000000,
  parameter int BASE_STEP_HZ        = 60,
  parameter int POS_W               = 10,
  parameter int X_MAX               = 639,
  parameter int Y_MAX               = 479,
  parameter int X_INIT              = 320,
  parameter int Y_INIT              = 240,
  parameter int QUAL_TICKS          = 3,
  parameter int MAX_SPEED           = 4
) (
  input  logic             SYSCLK,
  input  logic             reset2,
  input  logic [3:0]       tilt,
  input  logic             freeze,
  input  logic             recenter,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic             pos_valid,
  output logic             wall_hit,
  output logic             moving
);

  localparam int DIV   = SYSCLK_FREQUENCY_HZ / BASE_STEP_HZ;
  localparam int DIV_W = $clog2(DIV);

  logic [DIV_W-1:0]  div_cnt_p0;
  logic              tick_p0;
  logic signed [1:0] dir_x, dir_y;
  logic              stepped_x, stepped_y, clamped_x, clamped_y, in_move_x, in_move_y;

  function automatic logic signed [1:0] axis_dir(input logic neg, input logic pos);
    case ({neg, pos})
      2'b10:   return DIR_NEG;
      2'b01:   return DIR_POS;
      default: return DIR_NONE;
    endcase
  endfunction

  // Stage p0: free-running divider, keeps ticking through freeze
  always_ff @(posedge SYSCLK or negedge reset2) begin
    if (!reset2) begin
      div_cnt_p0 <= '0;
      tick_p0    <= 1'b0;
    end else begin
      tick_p0    <= (div_cnt_p0 == DIV_W'(DIV - 1));
      div_cnt_p0 <= (div_cnt_p0 == DIV_W'(DIV - 1)) ? '0 : div_cnt_p0 + 1'b1;
    end
  end

  assign dir_x = axis_dir(tilt[TILT_LEFT], tilt[TILT_RIGHT]);
  assign dir_y = axis_dir(tilt[TILT_FWD], tilt[TILT_BACK]);

  tilt_axis_stepper #(
    .POS_W(POS_W), .MAX_POS(X_MAX), .INIT_POS(X_INIT),
    .QUAL_TICKS(QUAL_TICKS), .MAX_SPEED(MAX_SPEED)
  ) u_axis_x (
    .SYSCLK(SYSCLK), .reset2(reset2), .tick(tick_p0), .dir(dir_x),
    .freeze(freeze), .recenter(recenter), .pos(ball_x),
    .stepped(stepped_x), .clamped(clamped_x), .in_move(in_move_x)
  );

  tilt_axis_stepper #(
    .POS_W(POS_W), .MAX_POS(Y_MAX), .INIT_POS(Y_INIT),
    .QUAL_TICKS(QUAL_TICKS), .MAX_SPEED(MAX_SPEED)
  ) u_axis_y (
    .SYSCLK(SYSCLK), .reset2(reset2), .tick(tick_p0), .dir(dir_y),
    .freeze(freeze), .recenter(recenter), .pos(ball_y),
    .stepped(stepped_y), .clamped(clamped_y), .in_move(in_move_y)
  );

  assign pos_valid = stepped_x | stepped_y;
  assign wall_hit  = clamped_x | clamped_y;
  assign moving    = in_move_x | in_move_y;

endmodule

// File: tb/tb_ball_tilt_stepper.sv
// Bench for ball_tilt_stepper: run-length reference model compared every cycle, plus directed literal checks.
module tb_ball_tilt_stepper;

  localparam int Q    = 3;
  localparam int MAXS = 4;
  localparam int XM   = 639;
  localparam int YM   = 479;
  localparam int XI   = 320;
  localparam int YI   = 240;
  localparam int DIVN = 10;
`ifdef BALL_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic       SYSCLK = 1'b0;
  logic       reset2 = 1'b0;
  logic [3:0] tilt = 4'b0000;
  logic       freeze = 1'b0;
  logic       recenter = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic       pos_valid, wall_hit, moving;

  always #5 SYSCLK = ~SYSCLK;

  ball_tilt_stepper #(
    .SYSCLK_FREQUENCY_HZ(1000), .BASE_STEP_HZ(100), .QUAL_TICKS(Q)
  ) dut (
    .SYSCLK(SYSCLK), .reset2(reset2), .tilt(tilt), .freeze(freeze), .recenter(recenter),
    .ball_x(ball_x), .ball_y(ball_y), .pos_valid(pos_valid), .wall_hit(wall_hit), .moving(moving)
  );

  int n_pass = 0;
  int n_total = 0;
  int pv_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: each axis tracks how many consecutive ticks the same nonzero direction was seen.
  function automatic int dir_of(input logic neg, input logic pos);
    if (neg && !pos) return -1;
    if (pos && !neg) return 1;
    return 0;
  endfunction

  function automatic int spd(input int run);
    if (!ACCEL) return 1;
    return (run - Q + 1 > MAXS) ? MAXS : run - Q + 1;
  endfunction

  function automatic int clampv(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  int m_x, m_y, m_valid, m_wall, run_x, run_y, h_x, h_y, pf_x, pf_y, pd_x, pd_y, m_div, m_tick;

  always @(posedge SYSCLK or negedge reset2) begin
    int dx, dy, nx, ny;
    if (!reset2) begin
      m_x = XI; m_y = YI; m_valid = 0; m_wall = 0;
      run_x = 0; run_y = 0; h_x = 0; h_y = 0;
      pf_x = 0; pf_y = 0; pd_x = 0; pd_y = 0; m_div = 0; m_tick = 0;
    end else begin
      dx = dir_of(tilt[0], tilt[1]);
      dy = dir_of(tilt[2], tilt[3]);
      m_valid = 0; m_wall = 0;
      if (recenter) begin
        m_x = XI; m_y = YI;
      end else if (!freeze && (pf_x != 0 || pf_y != 0)) begin
        m_valid = 1;
        if (pf_x != 0) begin
          nx = m_x + pd_x;
          if (nx < 0 || nx > XM) m_wall = 1;
          m_x = clampv(nx, XM);
        end
        if (pf_y != 0) begin
          ny = m_y + pd_y;
          if (ny < 0 || ny > YM) m_wall = 1;
          m_y = clampv(ny, YM);
        end
      end
      if (freeze) begin
        run_x = 0; run_y = 0; pf_x = 0; pf_y = 0;
      end else if (m_tick != 0) begin
        if (dx == 0) run_x = 0;
        else if (dx == h_x && run_x > 0) run_x = (run_x < 100) ? run_x + 1 : run_x;
        else begin h_x = dx; run_x = 1; end
        if (dy == 0) run_y = 0;
        else if (dy == h_y && run_y > 0) run_y = (run_y < 100) ? run_y + 1 : run_y;
        else begin h_y = dy; run_y = 1; end
        pf_x = (run_x >= Q) ? 1 : 0;
        pf_y = (run_y >= Q) ? 1 : 0;
        pd_x = h_x * spd(run_x);
        pd_y = h_y * spd(run_y);
      end else begin
        pf_x = 0; pf_y = 0;
      end
      m_tick = (m_div == DIVN - 1) ? 1 : 0;
      m_div = (m_div == DIVN - 1) ? 0 : m_div + 1;
    end
  end

  always @(negedge SYSCLK) begin
    if (cmp_en) begin
      chk("cyc_ball_x", int'(ball_x), m_x);
      chk("cyc_ball_y", int'(ball_y), m_y);
      chk("cyc_pos_valid", int'(pos_valid), m_valid);
      chk("cyc_wall_hit", int'(wall_hit), m_wall);
      chk("cyc_moving", int'(moving), (run_x >= Q || run_y >= Q) ? 1 : 0);
    end
    if (pos_valid) pv_cnt++;
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge SYSCLK);
      n++;
    end while (!pos_valid && n < 50);
    if (!pos_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    int n, ex, x0, y0;
    bit hit;
    repeat (3) @(negedge SYSCLK);
    cmp_en = 1'b1;
    chk("rst_x", int'(ball_x), 320);
    chk("rst_y", int'(ball_y), 240);
    chk("rst_pos_valid", int'(pos_valid), 0);
    chk("rst_wall_hit", int'(wall_hit), 0);
    chk("rst_moving", int'(moving), 0);
    reset2 = 1'b1;

    // Idle for 100 cycles
    pv_cnt = 0;
    repeat (100) @(negedge SYSCLK);
    chk("t1_pv_count", pv_cnt, 0);
    chk("t1_x", int'(ball_x), 320);
    chk("t1_y", int'(ball_y), 240);

    // Right held: 321,322,323,... or 321,323,326,330,334 with ramp
    tilt = 4'b0010;
    ex = 320;
    for (int k = 1; k <= 5; k++) begin
      wait_valid(n);
      ex += ACCEL ? ((k > MAXS) ? MAXS : k) : 1;
      chk("t2_x", int'(ball_x), ex);
      chk("t2_y", int'(ball_y), 240);
    end
    chk("t2_moving", int'(moving), 1);
    chk("t2_x_literal", int'(ball_x), ACCEL ? 334 : 325);
    tilt = 4'b0000;
    repeat (30) @(negedge SYSCLK);
    chk("t2_stopped", int'(moving), 0);
    x0 = int'(ball_x);

    // Left+right cancel, forward moves y up
    tilt = 4'b0111;
    wait_valid(n);
    chk("t3_x_hold", int'(ball_x), x0);
    chk("t3_y1", int'(ball_y), 239);
    chk("t3_moving", int'(moving), 1);
    wait_valid(n);
    chk("t3_y2", int'(ball_y), ACCEL ? 237 : 238);
    tilt = 4'b0000;
    repeat (30) @(negedge SYSCLK);
    y0 = int'(ball_y);

    // Run right into the wall
    tilt = 4'b0010;
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      wait_valid(n);
      if (!pos_valid) break;
      if (wall_hit) hit = 1'b1;
    end
    chk("t4_wall_seen", int'(hit), 1);
    chk("t4_x_wall", int'(ball_x), 639);
    chk("t4_y_hold", int'(ball_y), y0);
    for (int k = 0; k < 2; k++) begin
      wait_valid(n);
      chk("t4_x_held", int'(ball_x), 639);
      chk("t4_wall_again", int'(wall_hit), 1);
    end
    tilt = 4'b0000;
    @(negedge SYSCLK);
    recenter = 1'b1;
    @(negedge SYSCLK);
    recenter = 1'b0;
    chk("t4_recenter_x", int'(ball_x), 320);
    chk("t4_recenter_y", int'(ball_y), 240);
    repeat (30) @(negedge SYSCLK);

    // Right for two ticks then left: left needs a full fresh qualification
    pv_cnt = 0;
    tilt = 4'b0010;
    repeat (20) @(negedge SYSCLK);
    chk("t5_no_motion", pv_cnt, 0);
    tilt = 4'b0001;
    wait_valid(n);
    chk("t5_latency_ge21", int'(n >= 21), 1);
    chk("t5_x", int'(ball_x), 319);

    // Recenter collides with a step edge
    wait_valid(n);
    repeat (9) @(negedge SYSCLK);
    recenter = 1'b1;
    @(negedge SYSCLK);
    recenter = 1'b0;
    chk("t6_recenter_x", int'(ball_x), 320);
    chk("t6_recenter_y", int'(ball_y), 240);
    chk("t6_recenter_no_pv", int'(pos_valid), 0);
    pv_cnt = 0;
    freeze = 1'b1;
    repeat (40) @(negedge SYSCLK);
    chk("t6_freeze_pv", pv_cnt, 0);
    chk("t6_freeze_moving", int'(moving), 0);
    chk("t6_freeze_x", int'(ball_x), 320);
    freeze = 1'b0;
    wait_valid(n);
    chk("t6_release_x", int'(ball_x), 319);
    chk("t6_moving_before_rst", int'(moving), 1);
    #2 reset2 = 1'b0;
    #1;
    chk("t6_async_rst_x", int'(ball_x), 320);
    chk("t6_async_rst_y", int'(ball_y), 240);
    chk("t6_async_rst_moving", int'(moving), 0);
    chk("t6_async_rst_pv", int'(pos_valid), 0);
    repeat (3) @(negedge SYSCLK);
    reset2 = 1'b1;
    repeat (5) @(negedge SYSCLK);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
